// File: rtl/aes_pkg.sv
// Shared types, GF(2^8) helpers and column/byte indexing for the MixColumns engine.
package aes_pkg;

  typedef enum logic [1:0] {
    MC_FWD = 2'b00,
    MC_INV = 2'b01,
    MC_BYP = 2'b10
  } mc_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mc_state_t;

  // Circulant first rows; byte k sits at bits [8*(3-k) +: 8].
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Reserved encoding 2'b11 folds into bypass.
  function automatic mc_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return MC_FWD;
      2'b01:   return MC_INV;
      default: return MC_BYP;
    endcase
  endfunction

  function automatic logic [7:0] coef(input mc_mode_t mode, input logic [1:0] k);
    return (mode == MC_INV) ? INV_COEF[{~k, 3'b000} +: 8] : FWD_COEF[{~k, 3'b000} +: 8];
  endfunction

  // Row 0 is the most significant byte of a column word.
  function automatic logic [7:0] col_byte(input logic [31:0] col, input logic [1:0] row);
    return col[{~row, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] col, input logic [1:0] row,
                                           input logic [7:0] v);
    logic [31:0] r;
    r = col;
    r[{~row, 3'b000} +: 8] = v;
    return r;
  endfunction

  // Column 0 is the most significant word of the state.
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    return s[{~c, 5'b00000} +: 32];
  endfunction

  function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = s;
    r[{~c, 5'b00000} +: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns / bypass.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  mc_mode_t    mode,
  output logic [31:0] col_out
);

  logic [7:0] acc;

  // Each output row is the circulant row (rotated by row index) dotted with the column.
  always_comb begin
    col_out = col_in;
    acc     = '0;
    if (mode != MC_BYP) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          acc ^= gf_mul(coef(mode, 2'(j - r)), col_byte(col_in, 2'(j)));
        end
        col_out = put_byte(col_out, 2'(r), acc);
      end
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in place, then presents the result until downstream takes it.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned N       = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  CntStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  CntLast = 2'(4 - COLS_PER_CYCLE);

  mc_state_t    st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d, state_upd;
  mc_mode_t     mode_q, mode_d;
  logic         out_valid_q;

  logic [31:0]  col_res [COLS_PER_CYCLE];

  for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
    logic [1:0]  idx;
    logic [31:0] cin;
    assign idx = cnt_q + 2'(u);
    assign cin = get_col(state_q, idx);
    mix_column_unit u_mcu (
      .col_in  (cin),
      .mode    (mode_q),
      .col_out (col_res[u])
    );
  end

  // Write the freshly transformed columns back over their source slots.
  always_comb begin
    state_upd = state_q;
    for (int u = 0; u < int'(COLS_PER_CYCLE); u++) begin
      state_upd = put_col(state_upd, cnt_q + 2'(u), col_res[u]);
    end
  end

  // Next-state logic and the combinational in_ready.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    mode_d   = mode_q;
    in_ready = 1'b0;
    unique case (st_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_state;
          mode_d  = decode_mode(in_mode);
          cnt_d   = '0;
          st_d    = StBusy;
        end
      end
      StBusy: begin
        state_d = state_upd;
        cnt_d   = cnt_q + CntStep;
        if (cnt_q == CntLast) st_d = StDone;
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_d = in_state;
            mode_d  = decode_mode(in_mode);
            cnt_d   = '0;
            st_d    = StBusy;
          end else begin
            st_d = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // State, datapath and registered out_valid; reset discards any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      state_q     <= '0;
      mode_q      <= MC_FWD;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_valid_q <= (st_d == StDone);
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = state_q;

  // N documents the per-block compute cycles; referenced here so it is not dead.
  if (N == 0) begin : g_bad_n
    $error("derived cycle count must be nonzero");
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle)
// driven from one directed sequence, with a per-instance scoreboard.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [1:0]   in_mode   [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] exp_q [3][$];
  int acc_cyc  [3];
  int prev_acc [3];
  int rcvd     [3];
  int sent     [3];
  bit lat_wait [3];
  bit have_prev[3];
  bit tp_chk   [3];
  bit acc_flag [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  // Reference model.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mcol(input logic [31:0] c, input logic [1:0] m);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    if (m == 2'b00)
      return {gm(8'h02, s0) ^ gm(8'h03, s1) ^ s2 ^ s3,
              s0 ^ gm(8'h02, s1) ^ gm(8'h03, s2) ^ s3,
              s0 ^ s1 ^ gm(8'h02, s2) ^ gm(8'h03, s3),
              gm(8'h03, s0) ^ s1 ^ s2 ^ gm(8'h02, s3)};
    else if (m == 2'b01)
      return {gm(8'h0e, s0) ^ gm(8'h0b, s1) ^ gm(8'h0d, s2) ^ gm(8'h09, s3),
              gm(8'h09, s0) ^ gm(8'h0e, s1) ^ gm(8'h0b, s2) ^ gm(8'h0d, s3),
              gm(8'h0d, s0) ^ gm(8'h09, s1) ^ gm(8'h0e, s2) ^ gm(8'h0b, s3),
              gm(8'h0b, s0) ^ gm(8'h0d, s1) ^ gm(8'h09, s2) ^ gm(8'h0e, s3)};
    else
      return c;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [1:0] m);
    logic [127:0] r;
    r = s;
    for (int c = 0; c < 4; c++) r[32*(3-c) +: 32] = mcol(s[32*(3-c) +: 32], m);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: monitor handshakes at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    logic [127:0] e;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      acc_flag[d] = 1'b0;
      if (out_valid[d] === 1'b1) begin
        if (lat_wait[d]) begin
          chk($sformatf("latency_d%0d", d), 128'(cyc - acc_cyc[d]), 128'((4 >> d) + 1));
          lat_wait[d] = 1'b0;
        end
        if (out_ready[d] === 1'b1) begin
          chk($sformatf("sb_depth_d%0d", d), 128'(exp_q[d].size()), 128'(1));
          if (exp_q[d].size() > 0) begin
            e = exp_q[d].pop_front();
            chk($sformatf("sb_data_d%0d", d), out_state[d], e);
          end
          rcvd[d]++;
        end
      end
      if (in_valid[d] === 1'b1 && in_ready[d] === 1'b1) begin
        exp_q[d].push_back(model(in_state[d], in_mode[d]));
        acc_cyc[d]  = cyc;
        lat_wait[d] = 1'b1;
        acc_flag[d] = 1'b1;
        if (tp_chk[d] && have_prev[d])
          chk($sformatf("interval_d%0d", d), 128'(cyc - prev_acc[d]), 128'((4 >> d) + 1));
        prev_acc[d]  = cyc;
        have_prev[d] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] s, input logic [1:0] m);
    int n;
    in_state[d] = s;
    in_mode[d]  = m;
    in_valid[d] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag[d] && n < 50);
    chk($sformatf("accepted_d%0d", d), 128'(acc_flag[d]), 128'(1));
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d);
    int n;
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("out_valid_seen_d%0d", d), 128'(out_valid[d]), 128'(1));
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [127:0] s, e;
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_mode[d]   = 2'b00;
      in_state[d]  = '0;
      lat_wait[d]  = 1'b0;
      have_prev[d] = 1'b0;
      tp_chk[d]    = 1'b0;
      acc_flag[d]  = 1'b0;
      rcvd[d]      = 0;
      sent[d]      = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid_d%0d", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("rst_out_state_d%0d", d), out_state[d], 128'(0));
      chk($sformatf("rst_in_ready_d%0d", d), 128'(in_ready[d]), 128'(1));
    end
    rst_n = 1'b1;

    // FIPS-197 forward column vector, one column per cycle.
    send(0, 128'hdb135345_c6c6c6c6_d4d4d4d5_2d26314c, 2'b00);
    wait_out(0);
    chk("fips_fwd", out_state[0], 128'h8e4da1bc_c6c6c6c6_d5d5d7d6_4d7ebdf8);
    drain(0);

    // Inverse, four columns per cycle.
    send(2, 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8, 2'b01);
    wait_out(2);
    chk("fips_inv", out_state[2], 128'hdb135345_f20a225c_c6c6c6c6_2d26314c);
    drain(2);

    // Bypass and reserved mode on every width.
    for (int d = 0; d < 3; d++) begin
      s = rnd128();
      send(d, s, (d == 1) ? 2'b11 : 2'b10);
      wait_out(d);
      chk($sformatf("bypass_d%0d", d), out_state[d], s);
      drain(d);
    end

    // Backpressure in DONE with a pending input.
    s = rnd128();
    e = model(s, 2'b00);
    send(0, s, 2'b00);
    wait_out(0);
    in_state[0] = rnd128();
    in_mode[0]  = 2'b01;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_state", out_state[0], e);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    out_ready[0] = 1'b1;
    tick();
    chk("bp_release_accept", 128'(acc_flag[0]), 128'(1));
    chk("bp_release_valid_fall", 128'(out_valid[0]), 128'(0));
    in_valid[0] = 1'b0;
    wait_out(0);
    tick();
    out_ready[0] = 1'b0;

    // Reset during the second BUSY cycle.
    send(0, 128'h0123456789abcdef_fedcba9876543210, 2'b00);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst_busy_out_state", out_state[0], 128'(0));
    exp_q[0].delete();
    lat_wait[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 128'(in_ready[0]), 128'(1));
    s = rnd128();
    send(0, s, 2'b01);
    wait_out(0);
    chk("post_rst_result", out_state[0], model(s, 2'b01));
    drain(0);

    // Random stream with random output stalls.
    for (int d = 0; d < 3; d++) begin
      rcvd[d]     = 0;
      in_state[d] = rnd128();
      in_mode[d]  = 2'($urandom_range(0, 3));
      in_valid[d] = 1'b1;
      sent[d]     = 1;
    end
    n = 0;
    while ((rcvd[0] < 100 || rcvd[1] < 100 || rcvd[2] < 100) && n < 6000) begin
      for (int d = 0; d < 3; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
      tick();
      n++;
      for (int d = 0; d < 3; d++) begin
        if (acc_flag[d]) begin
          if (sent[d] < 100) begin
            in_state[d] = rnd128();
            in_mode[d]  = 2'($urandom_range(0, 3));
            sent[d]++;
          end else begin
            in_valid[d] = 1'b0;
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("stream_count_d%0d", d), 128'(rcvd[d]), 128'(100));

    // Throughput with no stalls: one acceptance every N+1 cycles.
    for (int d = 0; d < 3; d++) begin
      have_prev[d] = 1'b0;
      tp_chk[d]    = 1'b1;
      out_ready[d] = 1'b1;
      in_state[d]  = rnd128();
      in_mode[d]   = 2'($urandom_range(0, 3));
      in_valid[d]  = 1'b1;
    end
    repeat (40) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        if (acc_flag[d]) begin
          in_state[d] = rnd128();
          in_mode[d]  = 2'($urandom_range(0, 3));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      tp_chk[d]   = 1'b0;
    end
    repeat (8) tick();
    for (int d = 0; d < 3; d++) chk($sformatf("sb_empty_d%0d", d), 128'(exp_q[d].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
